// File: rtl/set_job_issuer.sv
// set_job_issuer: host-side initiator for the SET point-counting engine.
// Jobs are queued in a small FIFO and issued one at a time over the engine's
// en/busy/valid handshake; each candidate result is queued for the host.

// Show-ahead synchronous FIFO. Push/pop are already qualified by the caller.
module sji_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty,
    output logic             o_full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [CW-1:0]    r_cnt;

    // Storage array; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wp] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (i_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rp];
    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == FULL_CNT);
endmodule

module set_job_issuer #(
    parameter int         JOB_DEPTH = 4,
    parameter int         RES_DEPTH = 4,
    parameter logic [9:0] TIMEOUT   = 10'd1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        job_wr,
    input  logic [23:0] job_central,
    input  logic [11:0] job_radius,
    input  logic [1:0]  job_mode,
    output logic        job_full,
    input  logic        res_rd,
    output logic [9:0]  res_data,
    output logic        res_empty,
    output logic        set_en,
    output logic [23:0] set_central,
    output logic [11:0] set_radius,
    output logic [1:0]  set_mode,
    input  logic        set_busy,
    input  logic        set_valid,
    input  logic [7:0]  set_candidate,
    output logic        err_timeout,
    output logic [15:0] jobs_done
);
    // state     | meaning
    // ----------+-----------------------------------------------------------
    // IDLE      | wait for a queued job and room for its result, then pop it
    // ISSUE     | set_en high for this single cycle, watchdog cleared
    // WAIT_BUSY | wait for the engine to raise busy (watchdog running)
    // RUN       | wait for the result strobe (watchdog running)
    // DRAIN     | wait for busy to fall before the next job may start
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t      r_state;
    logic        r_set_en;
    logic [23:0] r_set_central;
    logic [11:0] r_set_radius;
    logic [1:0]  r_set_mode;
    logic [9:0]  r_wdog;
    logic        r_err_timeout;
    logic [15:0] r_jobs_done;

    logic        w_job_push;
    logic        w_job_pop;
    logic        w_job_empty;
    logic        w_job_full;
    logic [37:0] w_job_head;
    logic        w_res_push;
    logic        w_res_pop;
    logic        w_res_empty;
    logic        w_res_full;
    logic [9:0]  w_res_head;
    logic [9:0]  w_res_wdata;

    // A write while full is dropped even if IDLE frees a slot this cycle.
    assign w_job_push = job_wr & ~w_job_full;
    // Only one job is ever outstanding, so a non-full result FIFO at pop
    // time guarantees the later result push has room.
    assign w_job_pop  = (r_state == S_IDLE) & ~w_job_empty & ~w_res_full;
    assign w_res_push = (r_state == S_RUN) & set_valid;
    assign w_res_pop  = res_rd & ~w_res_empty;
    assign w_res_wdata = {r_set_mode, set_candidate};

    sji_fifo #(
        .DEPTH (JOB_DEPTH),
        .WIDTH (38)
    ) u_job_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_job_push),
        .i_wdata ({job_central, job_radius, job_mode}),
        .i_pop   (w_job_pop),
        .o_rdata (w_job_head),
        .o_empty (w_job_empty),
        .o_full  (w_job_full)
    );

    sji_fifo #(
        .DEPTH (RES_DEPTH),
        .WIDTH (10)
    ) u_res_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_res_push),
        .i_wdata (w_res_wdata),
        .i_pop   (w_res_pop),
        .o_rdata (w_res_head),
        .o_empty (w_res_empty),
        .o_full  (w_res_full)
    );

    // Job sequencer: hold operands, pulse en, supervise busy/valid with watchdog.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_set_en      <= 1'b0;
            r_set_central <= '0;
            r_set_radius  <= '0;
            r_set_mode    <= '0;
            r_wdog        <= '0;
            r_err_timeout <= 1'b0;
            r_jobs_done   <= '0;
        end else begin
            r_set_en <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_job_pop) begin
                        {r_set_central, r_set_radius, r_set_mode} <= w_job_head;
                        r_set_en <= 1'b1;
                        r_state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_wdog  <= '0;
                    r_state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (set_busy) begin
                        r_wdog  <= '0;
                        r_state <= S_RUN;
                    end else if (r_wdog == TIMEOUT) begin
                        r_err_timeout <= 1'b1;
                        r_state       <= S_DRAIN;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                S_RUN: begin
                    if (set_valid) begin
                        r_jobs_done <= r_jobs_done + 1'b1;
                        r_state     <= S_DRAIN;
                    end else if (r_wdog == TIMEOUT) begin
                        r_err_timeout <= 1'b1;
                        r_state       <= S_DRAIN;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (!set_busy) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign job_full    = w_job_full;
    assign res_empty   = w_res_empty;
    // Head word is masked while empty so the stale array never shows.
    assign res_data    = w_res_empty ? 10'd0 : w_res_head;
    assign set_en      = r_set_en;
    assign set_central = r_set_central;
    assign set_radius  = r_set_radius;
    assign set_mode    = r_set_mode;
    assign err_timeout = r_err_timeout;
    assign jobs_done   = r_jobs_done;
endmodule

// File: tb/tb_set_job_issuer.sv
// Bench for set_job_issuer: engine model, host reader, and a result scoreboard.
module tb_set_job_issuer;
    logic        clk = 1'b0;
    logic        rst;
    logic        job_wr;
    logic [23:0] job_central;
    logic [11:0] job_radius;
    logic [1:0]  job_mode;
    logic        job_full;
    logic        res_rd;
    logic [9:0]  res_data;
    logic        res_empty;
    logic        set_en;
    logic [23:0] set_central;
    logic [11:0] set_radius;
    logic [1:0]  set_mode;
    logic        set_busy;
    logic        set_valid;
    logic [7:0]  set_candidate;
    logic        err_timeout;
    logic [15:0] jobs_done;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [9:0]  exp_q[$];
    int          en_cnt = 0;
    int          en_exp = 0;
    int          jobs_exp = 0;
    bit          eng_normal = 1'b1;
    int          eng_phase = 0;
    int          rd_mode = 0;
    int          rd_req = 0;
    int          stray_req = 0;

    set_job_issuer dut (
        .clk           (clk),
        .rst           (rst),
        .job_wr        (job_wr),
        .job_central   (job_central),
        .job_radius    (job_radius),
        .job_mode      (job_mode),
        .job_full      (job_full),
        .res_rd        (res_rd),
        .res_data      (res_data),
        .res_empty     (res_empty),
        .set_en        (set_en),
        .set_central   (set_central),
        .set_radius    (set_radius),
        .set_mode      (set_mode),
        .set_busy      (set_busy),
        .set_valid     (set_valid),
        .set_candidate (set_candidate),
        .err_timeout   (err_timeout),
        .jobs_done     (jobs_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name, input int budget);
        n_tests++;
        n_fail++;
        $display("FAIL %s: no event within %0d cycles", name, budget);
    endtask

    // Lattice points of the 16x16 grid inside the disks, combined per mode.
    function automatic logic [7:0] model_count(input logic [23:0] c, input logic [11:0] r,
                                               input logic [1:0] m);
        int cx[3];
        int cy[3];
        int rr[3];
        int n;
        bit in0, in1, in2, hit;
        cx[0] = int'(c[23:20]); cy[0] = int'(c[19:16]);
        cx[1] = int'(c[15:12]); cy[1] = int'(c[11:8]);
        cx[2] = int'(c[7:4]);   cy[2] = int'(c[3:0]);
        rr[0] = int'(r[11:8]);  rr[1] = int'(r[7:4]); rr[2] = int'(r[3:0]);
        n = 0;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                in0 = ((x-cx[0])*(x-cx[0]) + (y-cy[0])*(y-cy[0])) <= rr[0]*rr[0];
                in1 = ((x-cx[1])*(x-cx[1]) + (y-cy[1])*(y-cy[1])) <= rr[1]*rr[1];
                in2 = ((x-cx[2])*(x-cx[2]) + (y-cy[2])*(y-cy[2])) <= rr[2]*rr[2];
                case (m)
                    2'd0:    hit = in0;
                    2'd1:    hit = in0 | in1;
                    2'd2:    hit = in0 & in1;
                    default: hit = (in0 ^ in1) | in2;
                endcase
                if (hit) n++;
            end
        end
        return n[7:0];
    endfunction

    // Engine model: busy the cycle after en, one valid strobe, then busy falls.
    initial begin
        int lat;
        int stray_done;
        logic [23:0] cap_c;
        logic [11:0] cap_r;
        logic [1:0]  cap_m;
        stray_done = 0;
        lat = 0;
        set_busy = 1'b0; set_valid = 1'b0; set_candidate = 8'd0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                set_busy = 1'b0; set_valid = 1'b0; eng_phase = 0;
            end else if (eng_phase == 0) begin
                if (set_en && eng_normal) begin
                    cap_c = set_central; cap_r = set_radius; cap_m = set_mode;
                    lat = $urandom_range(1, 4);
                    eng_phase = 1;
                end else if (stray_req != stray_done) begin
                    stray_done++;
                    set_valid = 1'b1; set_candidate = 8'hA5;
                    eng_phase = 5;
                end
            end else if (eng_phase == 1) begin
                set_busy = 1'b1; eng_phase = 2;
            end else if (eng_phase == 2) begin
                lat--;
                if (lat == 0) begin
                    set_valid = 1'b1;
                    set_candidate = model_count(cap_c, cap_r, cap_m);
                    check("operands_held", {set_central, set_radius, set_mode}, {cap_c, cap_r, cap_m});
                    eng_phase = 3;
                end
            end else if (eng_phase == 3) begin
                set_valid = 1'b0;
                lat = $urandom_range(0, 2);
                if (lat == 0) begin set_busy = 1'b0; eng_phase = 0; end
                else eng_phase = 4;
            end else if (eng_phase == 4) begin
                lat--;
                if (lat == 0) begin set_busy = 1'b0; eng_phase = 0; end
            end else begin
                set_valid = 1'b0; eng_phase = 0;
            end
        end
    end

    // Host reader.
    initial begin
        int rd_done;
        rd_done = 0;
        res_rd = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rd_req != rd_done) begin rd_done++; res_rd = 1'b1; end
            else if (rd_mode == 2) res_rd = 1'b1;
            else if (rd_mode == 1) res_rd = ($urandom_range(0, 1) == 1);
            else res_rd = 1'b0;
        end
    end

    // Monitor: count en cycles, score every word the host actually pops.
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (set_en) en_cnt++;
                if (res_rd && !res_empty) begin
                    if (exp_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_result: got %0h required none", res_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", res_data, e);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic write_job(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m,
                             input bit accept, input bit gives_result);
        job_wr = 1'b1; job_central = c; job_radius = r; job_mode = m;
        if (accept) begin
            en_exp++;
            if (gives_result) begin
                exp_q.push_back({m, model_count(c, r, m)});
                jobs_exp++;
            end
        end
        tick();
    endtask

    task automatic write_rand(input bit accept, input bit gives_result);
        write_job(24'($urandom), 12'($urandom), 2'($urandom), accept, gives_result);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || eng_phase != 0) && t < budget) begin tick(); t++; end
        if (t >= budget) bound_fail(name, budget);
        repeat (6) tick();
    endtask

    initial begin
        int en0;
        int t;
        logic [15:0] jd;
        rst = 1'b1; job_wr = 1'b0; job_central = '0; job_radius = '0; job_mode = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_job_full", job_full, 0);
        check("rst_res_empty", res_empty, 1);
        check("rst_set_en", set_en, 0);
        check("rst_operands", {set_central, set_radius, set_mode}, 0);
        check("rst_err", err_timeout, 0);
        check("rst_jobs_done", jobs_done, 0);
        check("rst_res_data", res_data, 0);
        rst = 1'b0;
        tick();

        // Single directed job: disk of radius 3 at (4,4) holds 29 points.
        en0 = en_cnt;
        write_job(24'h440000, 12'h300, 2'd0, 1, 1);
        job_wr = 1'b0;
        t = 0;
        while (res_empty && t < 50) begin tick(); t++; end
        if (t >= 50) bound_fail("first_result_wait", 50);
        check("first_res_data", res_data, 10'h01D);
        check("first_en_pulses", en_cnt - en0, 1);
        rd_mode = 1;
        wait_idle(200, "first_drain");
        check("first_jobs_done", jobs_done, 1);

        // Random batches that never exceed one FIFO's worth outstanding.
        for (int b = 0; b < 8; b++) begin
            int k;
            k = $urandom_range(1, 4);
            for (int j = 0; j < k; j++) write_rand(1, 1);
            job_wr = 1'b0;
            wait_idle(500, "batch_drain");
            check("batch_jobs_done", jobs_done, jobs_exp);
            check("batch_en_count", en_cnt, en_exp);
        end

        // Fill the job FIFO, drop a write while full, park on a full result FIFO.
        rd_mode = 0;
        en0 = en_cnt;
        jd = jobs_done;
        for (int j = 0; j < 5; j++) write_rand(1, 1);
        job_wr = 1'b0;
        check("job_full_after_5", job_full, 1);
        write_rand(0, 0);
        job_wr = 1'b0;
        check("job_full_after_drop", job_full, 1);
        t = 0;
        while (job_full && t < 100) begin tick(); t++; end
        if (t >= 100) bound_fail("job_space_wait", 100);
        write_rand(1, 1);
        job_wr = 1'b0;
        repeat (150) tick();
        check("park_en_count", en_cnt - en0, 4);
        check("park_res_empty", res_empty, 0);
        check("park_job_full", job_full, 0);
        check("park_jobs_done", jobs_done, jd + 16'd4);
        rd_req++;
        t = 0;
        while ((en_cnt - en0) < 5 && t < 6) begin tick(); t++; end
        if (t >= 6) bound_fail("issue_after_read", 6);
        rd_mode = 1;
        wait_idle(800, "park_drain");
        check("park_total_en", en_cnt - en0, 6);
        check("park_jobs_total", jobs_done, jobs_exp);

        // Watchdog: engine ignores the first job; the rest still complete.
        rd_mode = 0;
        eng_normal = 1'b0;
        en0 = en_cnt;
        write_rand(1, 0);
        for (int j = 0; j < 4; j++) write_rand(1, 1);
        job_wr = 1'b0;
        check("to_job_full", job_full, 1);
        jd = jobs_done;
        write_rand(0, 0);
        job_wr = 1'b0;
        rd_mode = 2;
        tick();
        rd_mode = 0;
        repeat (3) tick();
        check("stray_full_keep", job_full, 1);
        check("stray_empty_keep", res_empty, 1);
        check("stray_jobs_done", jobs_done, jd);
        check("stray_en_count", en_cnt - en0, 1);
        t = 0;
        while (!err_timeout && t < 1200) begin tick(); t++; end
        eng_normal = 1'b1;
        if (t >= 1200) bound_fail("timeout_wait", 1200);
        check("timeout_not_early", (t >= 990) ? 1 : 0, 1);
        check("timeout_not_late", (t <= 1040) ? 1 : 0, 1);
        check("timeout_no_push", res_empty, 1);
        rd_mode = 1;
        wait_idle(800, "to_drain");
        check("to_en_count", en_cnt - en0, 5);
        check("to_jobs_done", jobs_done, jobs_exp);
        check("to_err_sticky", err_timeout, 1);

        // Reset in the middle of RUN, then a stray valid while idle.
        rd_mode = 0;
        write_rand(1, 1);
        job_wr = 1'b0;
        t = 0;
        while (eng_phase != 2 && t < 50) begin tick(); t++; end
        if (t >= 50) bound_fail("run_wait", 50);
        rst = 1'b1;
        #1;
        check("mid_rst_set_en", set_en, 0);
        check("mid_rst_operands", {set_central, set_radius, set_mode}, 0);
        check("mid_rst_err", err_timeout, 0);
        check("mid_rst_jobs_done", jobs_done, 0);
        check("mid_rst_job_full", job_full, 0);
        check("mid_rst_res_empty", res_empty, 1);
        exp_q.delete();
        jobs_exp = 0;
        tick(); tick();
        rst = 1'b0;
        tick();
        stray_req++;
        repeat (5) tick();
        check("post_rst_stray_empty", res_empty, 1);
        check("post_rst_stray_done", jobs_done, 0);
        write_rand(1, 1);
        job_wr = 1'b0;
        rd_mode = 1;
        wait_idle(200, "post_rst_drain");
        check("post_rst_jobs_done", jobs_done, 1);
        check("final_en_count", en_cnt, en_exp);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
